// File: rtl/string_scan_pkg.sv
// Package: string_scan_pkg
// Shared types and constants for the "0100" string scanner.
//   scan_state_t : sequencer states of string_scan_ctrl
//   PATTERN      : the serial pattern the detector recognises, MSB first
package string_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } scan_state_t;

  localparam logic [3:0] PATTERN = 4'b0100;

endpackage

// File: rtl/seq_detect_0100.sv
// Module: seq_detect_0100
// Bit-serial Moore detector for the overlapping pattern "0100".
// Ports:
//   clock   in  rising-edge clock
//   reset   in  asynchronous, active-high reset (forces state R)
//   clr     in  synchronous clear (forces state R on the next edge)
//   seq_in  in  serial input bit
//   seq_out out 1 only while in state D (pattern just completed)
module seq_detect_0100 (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic seq_in,
  output logic seq_out
);

  // R: nothing, A: "0", B: "01", C: "010", D: "0100"
  typedef enum logic [2:0] {
    R = 3'd0,
    A = 3'd1,
    B = 3'd2,
    C = 3'd3,
    D = 3'd4
  } det_state_t;

  det_state_t state;
  det_state_t state_nxt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= R;
    end else if (clr) begin
      state <= R;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = R;
    unique case (state)
      R:       state_nxt = seq_in ? R : A;
      A:       state_nxt = seq_in ? B : A;
      B:       state_nxt = seq_in ? R : C;
      C:       state_nxt = seq_in ? B : D;
      D:       state_nxt = seq_in ? B : A;
      default: state_nxt = R;
    endcase
  end

  assign seq_out = (state == D);

endmodule

// File: rtl/string_scan_ctrl.sv
// Module: string_scan_ctrl
// Word-level sequencer for the serial "0100" detector. A word accepted on
// start is shifted MSB-first into seq_detect_0100, one bit per clock; the
// overlapping matches are counted (saturating) and reported with a
// one-cycle done pulse.
// Parameters:
//   WORD_W  bits per scanned word (>=4)
//   CNT_W   match counter width, saturates at 2**CNT_W-1
//   POS_W   width of first_pos, = $clog2(WORD_W)
// Ports:
//   clock        in   rising-edge clock
//   reset        in   asynchronous, active-high reset
//   start        in   scan request, accepted only in IDLE
//   data_in      in   word to scan, sampled on an accepted start
//   busy         out  high from the cycle after accept through DONE
//   done         out  one-cycle pulse, match_count final
//   match_pulse  out  detector output qualified by SHIFT/FLUSH
//   match_count  out  overlapping matches in current/last word
//   first_pos    out  (STRING_SCAN_POS_EN) MSB-relative index of the last
//                     bit of the first match
//   first_vld    out  (STRING_SCAN_POS_EN) first_pos is valid
// Optional feature macro: STRING_SCAN_POS_EN
module string_scan_ctrl
  import string_scan_pkg::*;
#(
  parameter int unsigned WORD_W = 16,
  parameter int unsigned CNT_W  = 5,
  parameter int unsigned POS_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] data_in,
  output logic              busy,
  output logic              done,
  output logic              match_pulse,
`ifdef STRING_SCAN_POS_EN
  output logic [CNT_W-1:0]  match_count,
  output logic [POS_W-1:0]  first_pos,
  output logic              first_vld
`else
  output logic [CNT_W-1:0]  match_count
`endif
);

  localparam logic [POS_W-1:0] LAST_IDX = POS_W'(WORD_W - 1);

  scan_state_t       state;
  scan_state_t       state_nxt;
  logic [WORD_W-1:0] shreg;
  logic [POS_W-1:0]  idx;
  logic              accept;
  logic              scanning;
  logic              det_clr;
  logic              det_in;
  logic              det_out;

  // The detector has no enable, so it keeps stepping outside SHIFT. That is
  // harmless: its output is only counted in SHIFT/FLUSH, and FLUSH sees the
  // state produced by the last shifted bit.
  seq_detect_0100 u_det (
    .clock   (clock),
    .reset   (reset),
    .clr     (det_clr),
    .seq_in  (det_in),
    .seq_out (det_out)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    scanning  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy     = 1'b1;
        scanning = 1'b1;
        if (idx == LAST_IDX) begin
          state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        busy      = 1'b1;
        scanning  = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign det_clr     = accept;
  assign det_in      = shreg[WORD_W-1];
  assign match_pulse = scanning & det_out;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg       <= '0;
      idx         <= '0;
      match_count <= '0;
    end else begin
      if (accept) begin
        shreg       <= data_in;
        idx         <= '0;
        match_count <= '0;
      end else begin
        if (state == SHIFT) begin
          shreg <= {shreg[WORD_W-2:0], 1'b0};
          idx   <= idx + POS_W'(1);
        end
        if (match_pulse && (match_count != '1)) begin
          match_count <= match_count + CNT_W'(1);
        end
      end
    end
  end

`ifdef STRING_SCAN_POS_EN
  // The Moore output lags the shifted bit by one cycle, so the match ended
  // at idx-1 in SHIFT; in FLUSH idx has already wrapped, hence the constant.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      first_pos <= '0;
      first_vld <= 1'b0;
    end else if (accept) begin
      first_pos <= '0;
      first_vld <= 1'b0;
    end else if (match_pulse && !first_vld) begin
      first_pos <= (state == FLUSH) ? LAST_IDX : (idx - POS_W'(1));
      first_vld <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_string_scan_ctrl.sv
module tb_string_scan_ctrl;
  import string_scan_pkg::*;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned CNT_W  = 5;
  localparam int unsigned POS_W  = 4;

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [WORD_W-1:0] data_in;
  logic              busy, done, match_pulse;
  logic [CNT_W-1:0]  match_count;
  logic [POS_W-1:0]  first_pos;
  logic              first_vld;

  logic              s_start;
  logic [WORD_W-1:0] s_data_in;
  logic              s_busy, s_done, s_match_pulse;
  logic [1:0]        s_match_count;
  logic [POS_W-1:0]  s_first_pos;
  logic              s_first_vld;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  string_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W), .POS_W(POS_W)) u_dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .data_in     (data_in),
    .busy        (busy),
    .done        (done),
    .match_pulse (match_pulse),
`ifdef STRING_SCAN_POS_EN
    .match_count (match_count),
    .first_pos   (first_pos),
    .first_vld   (first_vld)
`else
    .match_count (match_count)
`endif
  );

  string_scan_ctrl #(.WORD_W(WORD_W), .CNT_W(2), .POS_W(POS_W)) u_sat (
    .clock       (clock),
    .reset       (reset),
    .start       (s_start),
    .data_in     (s_data_in),
    .busy        (s_busy),
    .done        (s_done),
    .match_pulse (s_match_pulse),
`ifdef STRING_SCAN_POS_EN
    .match_count (s_match_count),
    .first_pos   (s_first_pos),
    .first_vld   (s_first_vld)
`else
    .match_count (s_match_count)
`endif
  );

`ifndef STRING_SCAN_POS_EN
  assign first_pos   = '0;
  assign first_vld   = 1'b0;
  assign s_first_pos = '0;
  assign s_first_vld = 1'b0;
`endif

  typedef struct {
    logic [WORD_W-1:0] data;
    int                poke_at;
    int                exp_cnt;
    int                exp_pos;
    int                exp_vld;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pulse start for one cycle, then sample every falling edge until done.
  // Sample 1 is the first cycle after the accepting edge.
  task automatic run_scan(input logic [WORD_W-1:0] d, input int poke_at,
                          output int cycles, output int busy_cyc,
                          output int pulses, output int got_done);
    cycles = 0; busy_cyc = 0; pulses = 0; got_done = 0;
    @(negedge clock);
    start   = 1'b1;
    data_in = d;
    for (int i = 0; i < 100 && got_done == 0; i++) begin
      @(negedge clock);
      data_in = '0;
      cycles++;
      if (busy) busy_cyc++;
      if (match_pulse) pulses++;
      if (done) got_done = 1;
      start = (poke_at == cycles);
      if (start) data_in = 16'h4444;
    end
    start = 1'b0;
  endtask

  initial begin
    int cycles, busy_cyc, pulses, got_done, wrapped, prev, seen;

    vecs[0] = '{16'h4000, 0, 1, 3, 1};
    vecs[1] = '{16'h4924, 5, 5, 3, 1};   // start poked mid-scan
    vecs[2] = '{16'hFFFF, 0, 0, 0, 0};
    vecs[3] = '{16'h0000, 0, 0, 0, 0};
    vecs[4] = '{16'h0124, 0, 3, 9, 1};
    vecs[5] = '{16'h0004, 0, 1, 15, 1};  // match counted in FLUSH
    vecs[6] = '{16'h0002, 0, 0, 0, 0};   // ends "010": next word must not complete it
    vecs[7] = '{16'h0000, 0, 0, 0, 0};

    reset = 1'b1; start = 1'b0; data_in = '0;
    s_start = 1'b0; s_data_in = '0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pulse", match_pulse, 0);
    chk("rst_count", match_count, 0);
`ifdef STRING_SCAN_POS_EN
    chk("rst_first_pos", first_pos, 0);
    chk("rst_first_vld", first_vld, 0);
`endif
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_busy", busy, 0);

    // Back-to-back table: each start lands in the IDLE cycle after done.
    for (int v = 0; v < 8; v++) begin
      run_scan(vecs[v].data, vecs[v].poke_at, cycles, busy_cyc, pulses, got_done);
      chk($sformatf("v%0d_done_seen", v), got_done, 1);
      chk($sformatf("v%0d_latency", v), cycles, WORD_W + 2);
      chk($sformatf("v%0d_busy_cycles", v), busy_cyc, WORD_W + 2);
      chk($sformatf("v%0d_count", v), match_count, vecs[v].exp_cnt);
      chk($sformatf("v%0d_pulses", v), pulses, vecs[v].exp_cnt);
`ifdef STRING_SCAN_POS_EN
      chk($sformatf("v%0d_first_vld", v), first_vld, vecs[v].exp_vld);
      chk($sformatf("v%0d_first_pos", v), first_pos, vecs[v].exp_pos);
`endif
    end

    // Count holds after done; done is a single pulse.
    repeat (3) @(negedge clock);
    chk("hold_count", match_count, 0);
    chk("hold_done", done, 0);
    chk("hold_busy", busy, 0);
    run_scan(16'h4000, 0, cycles, busy_cyc, pulses, got_done);
    repeat (4) @(negedge clock);
    chk("hold_count_1", match_count, 1);

    // Async reset at SHIFT idx=7 of 16'h4924.
    @(negedge clock);
    start = 1'b1; data_in = 16'h4924;
    @(negedge clock);
    start = 1'b0;
    repeat (7) @(negedge clock);
    chk("mid_count_before_rst", match_count, 1);
    chk("mid_busy_before_rst", busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_count", match_count, 0);
    chk("mid_rst_pulse", match_pulse, 0);
    @(negedge clock);
    reset = 1'b0;
    seen = 0;
    repeat (25) begin
      @(negedge clock);
      if (done || busy) seen = 1;
    end
    chk("no_done_after_rst", seen, 0);
    run_scan(16'h4924, 0, cycles, busy_cyc, pulses, got_done);
    chk("post_rst_done_seen", got_done, 1);
    chk("post_rst_count", match_count, 5);

    // CNT_W=2 instance: five matches saturate at 3.
    @(negedge clock);
    s_start = 1'b1; s_data_in = 16'h4924;
    @(negedge clock);
    s_start = 1'b0;
    wrapped = 0; prev = 0; got_done = 0;
    for (int i = 0; i < 100 && got_done == 0; i++) begin
      if (int'(s_match_count) < prev) wrapped = 1;
      prev = int'(s_match_count);
      if (s_done) got_done = 1;
      else @(negedge clock);
    end
    chk("sat_done_seen", got_done, 1);
    chk("sat_count", s_match_count, 3);
    chk("sat_no_wrap", wrapped, 0);
`ifdef STRING_SCAN_POS_EN
    chk("sat_first_pos", s_first_pos, 3);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
